// File: rtl/wrfifo_occ_bp_ctrl.sv
// Write-FIFO occupancy tracker for multi-write-port memories: counts pushes, drains up to
// NUMWTPT entries per cycle, and drives hysteretic backpressure, sticky overflow and a high-watermark.
module wrfifo_occ_bp_ctrl #(
    parameter int NUMWRPT = 4,
    parameter int NUMWTPT = 2,
    parameter int BITFIFO = 8,
    parameter int BPDEL   = 1,
    parameter int BITDRN  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic [NUMWRPT-1:0] write,
    input  logic               drain_en,
    input  logic [BITFIFO:0]   bp_thr_hi,
    input  logic [BITFIFO:0]   bp_thr_lo,
    input  logic               hwm_clr,
    output logic [BITFIFO:0]   wrfifo_cnt,
    output logic [BITDRN-1:0]  drain_cnt,
    output logic [NUMWRPT-1:0] wr_bp,
    output logic               ovf_err,
    output logic [BITFIFO:0]   hwm
);

    localparam int FNUMWRDS = 2 ** BITFIFO;
    localparam int PW       = (BPDEL == 0) ? 1 : BPDEL;
    localparam logic [BITFIFO+1:0] FULL_X  = (BITFIFO+2)'(FNUMWRDS);
    localparam logic [BITFIFO:0]   DRN_MAX = (BITFIFO+1)'(NUMWTPT);

    typedef enum logic {
        BP_OFF = 1'b0,
        BP_ON  = 1'b1
    } bp_state_t;

    bp_state_t          state_q, state_d;
    logic [BITFIFO:0]   cnt_q, cnt_d;
    logic [BITFIFO:0]   hwm_q, hwm_d;
    logic               ovf_q, ovf_d;
    logic [PW-1:0]      pipe_q, pipe_d;
    logic [BITFIFO+1:0] ecnt;
    logic [BITFIFO:0]   dcnt;
    logic [BITFIFO+1:0] sum;
    logic [BITFIFO:0]   cnt_nxt;
    logic [BITFIFO:0]   lo_eff;

    always_comb begin
        ecnt = '0;
        for (int i = 0; i < NUMWRPT; i++) begin
            ecnt = ecnt + (BITFIFO+2)'(write[i]);
        end
        if (!ready) begin
            ecnt = '0;
        end

        // Drain only sees the start-of-cycle count, so same-cycle writes are never drained.
        dcnt = '0;
        if (ready && drain_en) begin
            dcnt = (cnt_q < DRN_MAX) ? cnt_q : DRN_MAX;
        end

        sum     = {1'b0, cnt_q} + ecnt - {1'b0, dcnt};
        cnt_nxt = (sum > FULL_X) ? FULL_X[BITFIFO:0] : sum[BITFIFO:0];
        ovf_d   = ovf_q | (sum > FULL_X);
        if (!ready) begin
            cnt_nxt = '0;
        end
        cnt_d  = cnt_nxt;
        lo_eff = (bp_thr_lo < bp_thr_hi) ? bp_thr_lo : bp_thr_hi;

        state_d = state_q;
        case (state_q)
            BP_OFF:  if (cnt_nxt > bp_thr_hi) state_d = BP_ON;
            BP_ON:   if (cnt_nxt <= lo_eff)   state_d = BP_OFF;
            default: state_d = BP_OFF;
        endcase

        // Output delay line carries the registered state; a flush empties it.
        pipe_d    = '0;
        pipe_d[0] = (state_q == BP_ON);
        for (int i = 1; i < PW; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (!ready) begin
            state_d = BP_OFF;
            pipe_d  = '0;
        end

        hwm_d = hwm_clr ? cnt_nxt : ((cnt_nxt > hwm_q) ? cnt_nxt : hwm_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BP_OFF;
            cnt_q   <= '0;
            hwm_q   <= '0;
            ovf_q   <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hwm_q   <= hwm_d;
            ovf_q   <= ovf_d;
            pipe_q  <= pipe_d;
        end
    end

    assign wrfifo_cnt = cnt_q;
    assign drain_cnt  = BITDRN'(dcnt);
    assign ovf_err    = ovf_q;
    assign hwm        = hwm_q;
    assign wr_bp      = {NUMWRPT{(BPDEL == 0) ? (state_q == BP_ON) : pipe_q[PW-1]}};

endmodule

// File: tb/tb_wrfifo_occ_bp_ctrl.sv
// Bench for wrfifo_occ_bp_ctrl: directed scenarios plus randomized traffic against an
// arithmetic occupancy/backpressure model.
module tb_wrfifo_occ_bp_ctrl;

    localparam int NUMWRPT = 4;
    localparam int NUMWTPT = 2;
    localparam int BITFIFO = 8;
    localparam int BPDEL   = 1;
    localparam int BITDRN  = 2;
    localparam int FDEPTH  = 2 ** BITFIFO;

    logic               clk = 1'b0;
    logic               rst;
    logic               ready;
    logic [NUMWRPT-1:0] write;
    logic               drain_en;
    logic [BITFIFO:0]   bp_thr_hi;
    logic [BITFIFO:0]   bp_thr_lo;
    logic               hwm_clr;
    logic [BITFIFO:0]   wrfifo_cnt;
    logic [BITDRN-1:0]  drain_cnt;
    logic [NUMWRPT-1:0] wr_bp;
    logic               ovf_err;
    logic [BITFIFO:0]   hwm;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_cnt;
    int m_hwm;
    bit m_bp;
    bit m_ovf;
    bit m_pipe[$];

    wrfifo_occ_bp_ctrl #(
        .NUMWRPT(NUMWRPT), .NUMWTPT(NUMWTPT), .BITFIFO(BITFIFO),
        .BPDEL(BPDEL), .BITDRN(BITDRN)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready), .write(write), .drain_en(drain_en),
        .bp_thr_hi(bp_thr_hi), .bp_thr_lo(bp_thr_lo), .hwm_clr(hwm_clr),
        .wrfifo_cnt(wrfifo_cnt), .drain_cnt(drain_cnt), .wr_bp(wr_bp),
        .ovf_err(ovf_err), .hwm(hwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_bp_bus();
        bit b;
        b = (BPDEL == 0) ? m_bp : m_pipe[BPDEL-1];
        return b ? (2 ** NUMWRPT) - 1 : 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_cnt"}, int'(wrfifo_cnt), m_cnt);
        check({tag, "_bp"},  int'(wr_bp),      exp_bp_bus());
        check({tag, "_ovf"}, int'(ovf_err),    int'(m_ovf));
        check({tag, "_hwm"}, int'(hwm),        m_hwm);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_hwm = 0;
        m_bp  = 1'b0;
        m_ovf = 1'b0;
        m_pipe.delete();
        for (int i = 0; i < BPDEL; i++) m_pipe.push_back(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ready = 1'b1; write = '0; drain_en = 1'b0; hwm_clr = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        check_all("reset");
    endtask

    // One clock: drive at negedge, check drain_cnt, then check registered outputs after the edge.
    task automatic step(input logic [NUMWRPT-1:0] w, input logic rdy, input logic de,
                        input logic clr, input string tag);
        int ec, dc, sum, lo_e;
        @(negedge clk);
        write = w; ready = rdy; drain_en = de; hwm_clr = clr;
        dc = (rdy && de) ? ((m_cnt < NUMWTPT) ? m_cnt : NUMWTPT) : 0;
        #1;
        check({tag, "_drn"}, int'(drain_cnt), dc);
        @(posedge clk);
        if (!rdy) begin
            m_cnt = 0;
            m_bp  = 1'b0;
            foreach (m_pipe[i]) m_pipe[i] = 1'b0;
        end else begin
            ec  = $countones(w);
            sum = m_cnt + ec - dc;
            if (sum > FDEPTH) m_ovf = 1'b1;
            m_cnt = (sum > FDEPTH) ? FDEPTH : sum;
            m_pipe.push_front(m_bp);
            void'(m_pipe.pop_back());
            lo_e = (int'(bp_thr_lo) < int'(bp_thr_hi)) ? int'(bp_thr_lo) : int'(bp_thr_hi);
            if (!m_bp && m_cnt > int'(bp_thr_hi)) m_bp = 1'b1;
            else if (m_bp && m_cnt <= lo_e)      m_bp = 1'b0;
        end
        m_hwm = clr ? m_cnt : ((m_cnt > m_hwm) ? m_cnt : m_hwm);
        #1;
        check_all(tag);
    endtask

    initial begin
        int c;
        int pdrn;
        rst = 1'b1; ready = 1'b1; write = '0; drain_en = 1'b0; hwm_clr = 1'b0;
        bp_thr_hi = 9'd200; bp_thr_lo = 9'd200;

        // fill at 4 entries/cycle with single threshold 200
        do_reset();
        for (int i = 0; i < 64; i++) begin
            step(4'hF, 1'b1, 1'b0, 1'b0, "t1");
            check("t1_cnt_ramp", int'(wrfifo_cnt), 4 * (i + 1));
            check("t1_bp_edge", int'(wr_bp), (4 * (i + 1) >= 208) ? 15 : 0);
        end
        check("t1_no_ovf", int'(ovf_err), 0);

        // overflow is saturating and sticky through a full drain
        step(4'h1, 1'b1, 1'b0, 1'b0, "t2");
        check("t2_sat", int'(wrfifo_cnt), 256);
        check("t2_ovf", int'(ovf_err), 1);
        for (int i = 0; i < 130; i++) step(4'h0, 1'b1, 1'b1, 1'b0, "t2d");
        check("t2_empty", int'(wrfifo_cnt), 0);
        check("t2_ovf_hold", int'(ovf_err), 1);

        // hysteresis hi=100 lo=60
        bp_thr_hi = 9'd100; bp_thr_lo = 9'd60;
        do_reset();
        for (int i = 0; i < 26; i++) step(4'hF, 1'b1, 1'b0, 1'b0, "t3f");
        check("t3_fill", int'(wrfifo_cnt), 104);
        for (int k = 1; k <= 25; k++) begin
            step(4'h0, 1'b1, 1'b1, 1'b0, "t3d");
            c = 104 - 2 * k;
            check("t3_cnt", int'(wrfifo_cnt), c);
            check("t3_hyst", int'(wr_bp), (c >= 60) ? 15 : 0);
        end

        // drain with concurrent writes, and drain of an empty FIFO
        do_reset();
        step(4'b0001, 1'b1, 1'b0, 1'b0, "t4a");
        step(4'b0011, 1'b1, 1'b1, 1'b0, "t4b");
        check("t4_cnt2", int'(wrfifo_cnt), 2);
        step(4'b0000, 1'b1, 1'b1, 1'b0, "t4c");
        check("t4_cnt0", int'(wrfifo_cnt), 0);
        step(4'b0000, 1'b1, 1'b1, 1'b0, "t4e");
        check("t4_empty_cnt", int'(wrfifo_cnt), 0);

        // ready flush keeps hwm; hwm_clr reloads with current count
        bp_thr_hi = 9'd100; bp_thr_lo = 9'd100;
        do_reset();
        for (int i = 0; i < 37; i++) step(4'hF, 1'b1, 1'b0, 1'b0, "t5f");
        step(4'b0011, 1'b1, 1'b0, 1'b0, "t5g");
        check("t5_cnt150", int'(wrfifo_cnt), 150);
        check("t5_hwm150", int'(hwm), 150);
        check("t5_bp_on", int'(wr_bp), 15);
        step(4'hF, 1'b0, 1'b1, 1'b0, "t5r");
        check("t5_flush_cnt", int'(wrfifo_cnt), 0);
        check("t5_flush_bp", int'(wr_bp), 0);
        check("t5_flush_hwm", int'(hwm), 150);
        step(4'b0001, 1'b1, 1'b0, 1'b1, "t5c");
        check("t5_clr_hwm", int'(hwm), 1);

        // randomized traffic with phased drain probability and threshold changes
        do_reset();
        pdrn = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                pdrn = $urandom_range(0, 100);
                bp_thr_hi = 9'($urandom_range(0, 300));
                bp_thr_lo = 9'($urandom_range(0, 300));
            end
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 99) < pdrn),
                 ($urandom_range(0, 99) == 0), "rnd");
            check("rnd_cnt_le_depth", int'(wrfifo_cnt <= 9'(FDEPTH)), 1);
            check("rnd_hwm_ge_cnt", int'(hwm >= wrfifo_cnt), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
